// File: rtl/axi4_mem_pkg.sv
// Shared types and helpers for the two-port AXI4 backing store.
// strb_merge works on a fixed maximum width; callers size-cast to their own word width.
package axi4_mem_pkg;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_t;

  localparam int RDW_OLD    = 0;
  localparam int RDW_NEW    = 1;
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_mem_rd_pipe.sv
// Read return pipeline: RD_LATENCY stages of {valid, err, data}.
// Data stages load only alongside a valid so the output word holds between reads.
module axi4_mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      err_q[0] <= vld_i & err_i;
      if (vld_i) data_q[0] <= data_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= vld_q[i-1] & err_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LATENCY-1];
  assign err_o  = err_q[RD_LATENCY-1];
  assign data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/axi4_mem_2p.sv
// Two-port word store with byte-strobe writes, selectable read-during-write result,
// out-of-range flags and a zero-fill sweep after every reset.
module axi4_mem_2p
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  wr_err,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  mem_state_t            state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic                  init_done_q;
  logic                  wr_err_q;

  logic                  run;
  logic                  wr_in;
  logic                  rd_in;
  logic                  wr_ok;
  logic                  rd_fire;
  logic                  rd_hit;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_new;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word_d;

  assign run    = (state_q == MEM_RUN);
  assign wr_in  = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_ok  = run & wr_en & wr_in;
  assign rd_fire = run & rd_en;
  assign wr_idx = wr_in ? wr_addr : '0;
  assign rd_idx = rd_in ? rd_addr : '0;
  assign wr_old = mem_q[wr_idx];
  assign rd_old = mem_q[rd_idx];
  assign wr_new = DATA_WIDTH'(strb_merge(MAX_DATA_W'(wr_old), MAX_DATA_W'(wr_data),
                                         MAX_STRB_W'(wr_strb)));

  // A colliding write targets the same word, so its merged value is the "new data" answer.
  assign rd_hit    = wr_en & wr_in & rd_in & (wr_addr == rd_addr);
  assign rd_word_d = !rd_in ? '0 :
                     (rd_hit && RDW_MODE == RDW_NEW) ? wr_new : rd_old;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        mem_q[wr_idx] <= wr_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_INIT;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      wr_err_q <= run & wr_en & ~wr_in;
      case (state_q)
        MEM_INIT: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_C) begin
            state_q     <= MEM_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= MEM_RUN;
      endcase
    end
  end

  axi4_mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (rd_fire),
    .err_i  (~rd_in),
    .data_i (rd_word_d),
    .vld_o  (rd_valid),
    .err_o  (rd_err),
    .data_o (rd_data)
  );

  assign wr_err    = wr_err_q;
  assign init_done = init_done_q;

endmodule
